la_pulse_receiver: RTL and testbench

- Receive end of the LA pulse link: counts the pulse bursts that the LA pulse generator drives onto a memristor-cell pin, once they have looped back or been re-emitted by the analog core.
- Input `pulse_in` is asynchronous. It is synchronized, qualified by minimum high width, and counted on its falling edge within an armed measurement window.
- Result (`count`, `match`, `timeout` and error flags) is returned to the management SoC over LA inputs.
- Sits in `user_proj_example` beside the pulse generator. Uses the same LA-selectable clock/reset muxing.

---
 rtl/la_pulse_if.sv | 28 ++
 rtl/la_pulse_receiver.sv | 151 +++++++++++++++
 tb/tb_la_pulse_receiver.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/la_pulse_if.sv
// Control and result bundle between the LA register block and the pulse receiver.
// The master drives arm/abort and the capture setup; the slave returns status and results.
interface la_pulse_if #(
   parameter int CNT_W = 8,
   parameter int WIN_W = 16
) ();
   logic             arm;
   logic             abort;
   logic [CNT_W-1:0] expected;
   logic [WIN_W-1:0] window_cycles;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] count;
   logic             match;
   logic             timeout;
   logic             overflow;
   logic             runt;

   modport master (
      output arm, abort, expected, window_cycles,
      input  busy, done, count, match, timeout, overflow, runt
   );

   modport slave (
      input  arm, abort, expected, window_cycles,
      output busy, done, count, match, timeout, overflow, runt
   );
endinterface

// File: rtl/la_pulse_receiver.sv
// Receive end of the LA pulse link: synchronizes pulse_in, qualifies each high run
// by width and counts completed pulses inside an armed measurement window.
module la_pulse_receiver #(
   parameter int CNT_W       = 8,
   parameter int WIN_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int MIN_WIDTH   = 1
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      pulse_in,
   la_pulse_if.slave lif
);
   typedef enum logic [1:0] {IDLE, WAIT_LOW, CAPTURE, DONE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_d_q, s_d_d;
   logic [3:0]             run_q, run_d;
   logic [WIN_W-1:0]       win_q, win_d;
   logic                   win_en_q, win_en_d;
   logic [CNT_W-1:0]       exp_q, exp_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   match_q, match_d;
   logic                   timeout_q, timeout_d;
   logic                   overflow_q, overflow_d;
   logic                   runt_q, runt_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic             s;
   logic             fall;
   logic             qual;
   logic             expire;
   logic             cnt_full;
   logic             hit;
   logic [CNT_W-1:0] count_inc;

   assign s         = sync_q[SYNC_STAGES-1];
   assign fall      = s_d_q & ~s;
   assign qual      = fall && (run_q >= 4'(MIN_WIDTH));
   assign expire    = win_en_q && (win_q == WIN_W'(1));
   assign cnt_full  = &count_q;
   assign count_inc = count_q + 1'b1;
   // A saturated counter cannot newly reach expected, so overflow never matches.
   assign hit       = qual && !cnt_full && (exp_q != '0) && (count_inc == exp_q);

   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], pulse_in};
      s_d_d      = s;
      run_d      = !s ? 4'd0 : ((&run_q) ? run_q : run_q + 4'd1);
      state_d    = state_q;
      win_d      = win_q;
      win_en_d   = win_en_q;
      exp_d      = exp_q;
      count_d    = count_q;
      match_d    = match_q;
      timeout_d  = timeout_q;
      overflow_d = overflow_q;
      runt_d     = runt_q;

      if (lif.abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (lif.arm) begin
                  state_d    = WAIT_LOW;
                  count_d    = '0;
                  match_d    = 1'b0;
                  timeout_d  = 1'b0;
                  overflow_d = 1'b0;
                  runt_d     = 1'b0;
                  win_d      = lif.window_cycles;
                  win_en_d   = (lif.window_cycles != '0);
                  exp_d      = lif.expected;
               end
            end
            // Skip any pulse already high at arm: capture opens only once s is low.
            WAIT_LOW: begin
               if (win_en_q) win_d = win_q - 1'b1;
               if (expire) begin
                  state_d   = DONE;
                  timeout_d = 1'b1;
               end else if (!s) begin
                  state_d = CAPTURE;
               end
            end
            CAPTURE: begin
               if (win_en_q) win_d = win_q - 1'b1;
               if (fall && !qual) runt_d = 1'b1;
               if (qual && cnt_full) overflow_d = 1'b1;
               if (qual && !cnt_full) count_d = count_inc;
               if (hit) begin
                  state_d = DONE;
                  match_d = 1'b1;
               end else if (expire) begin
                  state_d   = DONE;
                  timeout_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      busy_d = (state_d == WAIT_LOW) || (state_d == CAPTURE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         sync_q     <= '0;
         s_d_q      <= 1'b0;
         run_q      <= '0;
         win_q      <= '0;
         win_en_q   <= 1'b0;
         exp_q      <= '0;
         count_q    <= '0;
         match_q    <= 1'b0;
         timeout_q  <= 1'b0;
         overflow_q <= 1'b0;
         runt_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         s_d_q      <= s_d_d;
         run_q      <= run_d;
         win_q      <= win_d;
         win_en_q   <= win_en_d;
         exp_q      <= exp_d;
         count_q    <= count_d;
         match_q    <= match_d;
         timeout_q  <= timeout_d;
         overflow_q <= overflow_d;
         runt_q     <= runt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign lif.busy     = busy_q;
   assign lif.done     = done_q;
   assign lif.count    = count_q;
   assign lif.match    = match_q;
   assign lif.timeout  = timeout_q;
   assign lif.overflow = overflow_q;
   assign lif.runt     = runt_q;
endmodule

// File: tb/tb_la_pulse_receiver.sv
// Two receivers (MIN_WIDTH 1 and 3) share one stimulus stream; a history-based
// model predicts every output each cycle, plus directed literal expectations.
module tb_la_pulse_receiver;
   localparam int S    = 2;
   localparam int CMAX = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        pulse_in;
   logic        arm;
   logic        abort;
   logic [7:0]  expected;
   logic [15:0] window_cycles;

   la_pulse_if #(.CNT_W(8), .WIN_W(16)) lif_a ();
   la_pulse_if #(.CNT_W(8), .WIN_W(16)) lif_b ();

   assign lif_a.arm = arm;      assign lif_b.arm = arm;
   assign lif_a.abort = abort;  assign lif_b.abort = abort;
   assign lif_a.expected = expected;           assign lif_b.expected = expected;
   assign lif_a.window_cycles = window_cycles; assign lif_b.window_cycles = window_cycles;

   la_pulse_receiver #(.CNT_W(8), .WIN_W(16), .SYNC_STAGES(S), .MIN_WIDTH(1)) u_a (
      .clk(clk), .rst(rst), .pulse_in(pulse_in), .lif(lif_a));
   la_pulse_receiver #(.CNT_W(8), .WIN_W(16), .SYNC_STAGES(S), .MIN_WIDTH(3)) u_b (
      .clk(clk), .rst(rst), .pulse_in(pulse_in), .lif(lif_b));

   always #5 clk = ~clk;

   logic       d_busy [2], d_done [2], d_match [2], d_to [2], d_ov [2], d_rn [2];
   logic [7:0] d_cnt [2];
   assign d_busy[0] = lif_a.busy;     assign d_busy[1] = lif_b.busy;
   assign d_done[0] = lif_a.done;     assign d_done[1] = lif_b.done;
   assign d_match[0] = lif_a.match;   assign d_match[1] = lif_b.match;
   assign d_to[0] = lif_a.timeout;    assign d_to[1] = lif_b.timeout;
   assign d_ov[0] = lif_a.overflow;   assign d_ov[1] = lif_b.overflow;
   assign d_rn[0] = lif_a.runt;       assign d_rn[1] = lif_b.runt;
   assign d_cnt[0] = lif_a.count;     assign d_cnt[1] = lif_b.count;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: pulse_in history per cycle; s(t) is the sample S cycles earlier,
   // forced low for cycles whose sample predates the latest reset.
   bit hist [$];
   int last_rst = 0;
   bit mvalid = 0;
   int md [2];           // 0 idle, 1 waiting for low, 2 capturing, 3 done
   int mc [2], mat [2], mw [2], me [2];
   bit mmt [2], mto [2], mov [2], mrn [2];

   function automatic bit s_at(int t);
      if (t - S <= last_rst || t - S >= hist.size()) return 1'b0;
      return hist[t - S];
   endfunction

   function automatic int runlen(int t);
      int n = 0;
      for (int k = t - 1; k >= 0 && n < 15 && s_at(k); k--) n++;
      return n;
   endfunction

   task automatic mstep(input int i, input int minw, input int t);
      bit exp_now, hit;
      if (rst) begin
         md[i] = 0; mc[i] = 0; mmt[i] = 0; mto[i] = 0; mov[i] = 0; mrn[i] = 0;
         return;
      end
      exp_now = (md[i] == 1 || md[i] == 2) && mw[i] != 0 && t == mat[i] + mw[i];
      if (abort) md[i] = 0;
      else if (md[i] == 0 || md[i] == 3) begin
         if (arm) begin
            md[i] = 1; mc[i] = 0; mmt[i] = 0; mto[i] = 0; mov[i] = 0; mrn[i] = 0;
            mat[i] = t; mw[i] = int'(window_cycles); me[i] = int'(expected);
         end
      end else if (md[i] == 1) begin
         if (exp_now) begin md[i] = 3; mto[i] = 1; end
         else if (!s_at(t)) md[i] = 2;
      end else begin
         hit = 0;
         if (s_at(t - 1) && !s_at(t)) begin
            if (runlen(t) < minw) mrn[i] = 1;
            else if (mc[i] == CMAX) mov[i] = 1;
            else begin
               mc[i]++;
               hit = (me[i] != 0 && mc[i] == me[i]);
            end
         end
         if (hit) begin md[i] = 3; mmt[i] = 1; end
         else if (exp_now) begin md[i] = 3; mto[i] = 1; end
      end
   endtask

   always @(posedge clk) begin : mdl
      int t;
      t = hist.size();
      if (rst) begin last_rst = t; mvalid = 1; end
      mstep(0, 1, t);
      mstep(1, 3, t);
      hist.push_back(pulse_in);
   end

   always @(negedge clk) begin
      if (mvalid) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("busy%0d", i),  d_busy[i],  (md[i] == 1 || md[i] == 2));
            chk($sformatf("done%0d", i),  d_done[i],  (md[i] == 3));
            chk($sformatf("count%0d", i), d_cnt[i],   mc[i]);
            chk($sformatf("match%0d", i), d_match[i], mmt[i]);
            chk($sformatf("tmo%0d", i),   d_to[i],    mto[i]);
            chk($sformatf("ovf%0d", i),   d_ov[i],    mov[i]);
            chk($sformatf("runt%0d", i),  d_rn[i],    mrn[i]);
         end
      end
   end

   int cyc = 0;
   int arm_at = 0;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic pulse(input int hi, input int lo);
      pulse_in = 1'b1;
      repeat (hi) tick();
      pulse_in = 1'b0;
      repeat (lo) tick();
   endtask

   task automatic do_arm(input int e, input int w);
      expected = 8'(e);
      window_cycles = 16'(w);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      arm_at = cyc;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
   endtask

   task automatic wait_done();
      while (!d_done[0] && cyc - arm_at < 60) tick();
   endtask

   initial begin
      int k;
      int rem;
      rst = 1'b1; arm = 1'b0; abort = 1'b0; pulse_in = 1'b0;
      expected = '0; window_cycles = '0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_count", d_cnt[0], 0);
      chk("rst_busy", d_busy[0], 0);
      chk("rst_done", d_done[0], 0);
      repeat (4) tick();

      // basic match: five 1-high/1-low pulses, expected 5
      do_arm(5, 100);
      repeat (5) pulse(1, 1);
      k = 0;
      while (!d_done[0] && k < 20) begin tick(); k++; end
      chk("t1_latency_ok", (k <= S + 2), 1);
      chk("t1_done", d_done[0], 1);
      chk("t1_count", d_cnt[0], 5);
      chk("t1_match", d_match[0], 1);
      chk("t1_timeout", d_to[0], 0);
      chk("t1_b_runt", d_rn[1], 1);
      chk("t1_b_count", d_cnt[1], 0);

      // timeout: 3 pulses in a 20-cycle window, last pulse high across expiry
      do_abort();
      do_arm(8, 20);
      repeat (3) pulse(3, 2);
      pulse_in = 1'b1;
      wait_done();
      chk("t2_done_cycle", cyc - arm_at, 20);
      chk("t2_count", d_cnt[0], 3);
      chk("t2_b_count", d_cnt[1], 3);
      chk("t2_timeout", d_to[0], 1);
      chk("t2_match", d_match[0], 0);

      // high at arm, then runt rejection on the MIN_WIDTH=3 receiver
      do_abort();
      repeat (2) tick();
      do_arm(0, 0);
      repeat (5) tick();
      chk("t3_wait_busy", d_busy[0], 1);
      chk("t3_wait_count", d_cnt[0], 0);
      pulse_in = 1'b0;
      repeat (3) tick();
      pulse(2, 4);
      chk("t3_b_runt", d_rn[1], 1);
      chk("t3_b_count", d_cnt[1], 0);
      chk("t3_a_count", d_cnt[0], 1);
      chk("t3_a_runt", d_rn[0], 0);
      pulse(4, 4);
      chk("t3_b_count2", d_cnt[1], 1);
      chk("t3_a_count2", d_cnt[0], 2);

      // overflow: 257 pulses, unbounded window, no match
      do_abort();
      do_arm(0, 0);
      repeat (257) pulse(1, 1);
      repeat (4) tick();
      do_abort();
      chk("t4_count", d_cnt[0], 255);
      chk("t4_ovf", d_ov[0], 1);
      chk("t4_busy", d_busy[0], 0);
      chk("t4_done", d_done[0], 0);

      // 4th qualified edge in the last window cycle: match wins
      repeat (3) tick();
      do_arm(4, 10);
      repeat (4) pulse(1, 1);
      wait_done();
      chk("t5_done_cycle", cyc - arm_at, 10);
      chk("t5_match", d_match[0], 1);
      chk("t5_timeout", d_to[0], 0);
      chk("t5_count", d_cnt[0], 4);
      chk("t5_b_timeout", d_to[1], 1);

      // arm and abort together
      do_abort();
      arm = 1'b1; abort = 1'b1;
      tick();
      arm = 1'b0; abort = 1'b0;
      chk("t6_busy", d_busy[0], 0);
      chk("t6_done", d_done[0], 0);
      tick();
      chk("t6_busy2", d_busy[0], 0);

      // reset mid-capture
      do_arm(0, 0);
      repeat (2) pulse(3, 3);
      repeat (2) tick();
      chk("t7_count", d_cnt[0], 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t7_rst_count", d_cnt[0], 0);
      chk("t7_rst_busy", d_busy[0], 0);
      chk("t7_rst_flags", {d_match[0], d_to[0], d_ov[0], d_rn[0], d_done[0]}, 0);
      repeat (2) tick();
      do_arm(0, 0);
      pulse(3, 3);
      repeat (2) tick();
      chk("t7_recount", d_cnt[0], 1);

      // randomized traffic, checked every cycle against the model
      rem = 0;
      repeat (3000) begin
         if (rem == 0) begin
            pulse_in = ~pulse_in;
            rem = $urandom_range(1, 6);
         end
         rem--;
         arm = ($urandom_range(0, 19) == 0);
         abort = ($urandom_range(0, 79) == 0);
         rst = ($urandom_range(0, 399) == 0);
         expected = 8'($urandom_range(0, 6));
         window_cycles = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 60));
         tick();
      end
      arm = 1'b0; abort = 1'b0; rst = 1'b0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
